nibble_fifo_ctrl: RTL

- FIFO controller wrapping one dual-port 2K x 9 / 4K x 4 block RAM used as an asymmetric FIFO.
- The byte-wide producer writes through RAM port B; the nibble-wide consumer (kcpsm3-side peripheral logic) reads through RAM port A.
- Sits directly upstream of the block RAM and drives every RAM port signal.
- Owns the write and read pointers, occupancy level, flow-control flags, sticky error flags and read-valid timing.

---
 rtl/nibble_fifo_ctrl.sv | 100 ++++++++++
 1 files changed

// File: rtl/nibble_fifo_ctrl.sv
// Asymmetric FIFO controller: byte writes on RAM port B, nibble reads on RAM port A.
// Define NIBBLE_FIFO_PARITY_GEN_EN to drive odd parity over each written byte onto ram_dipb.
module nibble_fifo_ctrl #(
  parameter int unsigned BYTE_AW = 11,
  parameter int unsigned NIB_AW  = 12,
  parameter int unsigned LVL_W   = 13
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [7:0]         wr_data,
  output logic               wr_ready,
  input  logic               rd_en,
  output logic [3:0]         rd_data,
  output logic               rd_valid,
  output logic               empty,
  output logic [LVL_W-1:0]   level,
  output logic               overflow,
  output logic               underflow,
  output logic [BYTE_AW-1:0] ram_addrb,
  output logic [7:0]         ram_dib,
  output logic               ram_dipb,
  output logic               ram_enb,
  output logic               ram_web,
  output logic [NIB_AW-1:0]  ram_addra,
  output logic               ram_ena,
  output logic               ram_wea,
  input  logic [3:0]         ram_doa
);

  // Largest level that still has room for a whole byte (two nibbles).
  localparam logic [LVL_W-1:0] WrLimit = LVL_W'((1 << NIB_AW) - 2);

  logic [BYTE_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [NIB_AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               rd_valid_q, overflow_q, underflow_q;
  logic               wr_acc, rd_acc;

  always_comb begin
    empty    = (level_q == '0);
    wr_ready = (level_q <= WrLimit) & ~reset;
    wr_acc   = wr_en & wr_ready;
    rd_acc   = rd_en & ~empty & ~reset;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + BYTE_AW'(1);
      level_d  = level_d + LVL_W'(2);
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + NIB_AW'(1);
      level_d  = level_d - LVL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      rd_valid_q  <= rd_acc;
      overflow_q  <= overflow_q | (wr_en & ~wr_ready);
      underflow_q <= underflow_q | (rd_en & empty);
    end
  end

  always_comb begin
    level     = level_q;
    rd_valid  = rd_valid_q;
    overflow  = overflow_q;
    underflow = underflow_q;
    // RAM holds its output while ram_ena is low, so rd_data stays stable between reads.
    rd_data   = ram_doa;
    ram_addrb = wr_ptr_q;
    ram_dib   = wr_data;
    ram_enb   = wr_acc;
    ram_web   = wr_acc;
    ram_addra = rd_ptr_q;
    ram_ena   = rd_acc;
    ram_wea   = 1'b0;
`ifdef NIBBLE_FIFO_PARITY_GEN_EN
    ram_dipb  = ~^wr_data;
`else
    ram_dipb  = 1'b0;
`endif
  end

endmodule
